cam_frame_capture: RTL and testbench
====================================

Name: cam_frame_capture

Overview:
- Upstream stage of the flash writer in the frame-acquisition path.
- Samples an asynchronous 8-bit parallel camera bus (PCLK/VSYNC/HREF/D[7:0]) in the system clock domain, then captures exactly one frame starting at the next frame boundary.
- Buffers the captured bytes in a small FIFO.
- Presents the bytes to the flash writer over a valid/ready interface with consecutive byte addresses starting at 0.

Parameters:
- MAX_BYTES, 200: byte budget per capture; capture stops once this many bytes have been pushed.
- FIFO_DEPTH, 4: buffer entries; must be a power of 2, at least 2.
- ADDR_W, 22: width of the flash byte address.

Ports:
- clock  in  1  system clock; all state is on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse that arms a capture; ignored while busy.
- cam_pclk  in  1  camera pixel clock, asynchronous; its frequency is at most clock/4.
- cam_vsync  in  1  frame sync, high between frames.
- cam_href  in  1  line valid.
- cam_data  in  8  pixel byte, stable around the rising edge of cam_pclk.
- wr_ready  in  1  flash writer accepts the byte.
- wr_valid  out  1  byte available at the FIFO head.
- wr_addr  out  ADDR_W  address of the head byte.
- wr_data  out  8  head byte (first-word fall-through).
- busy  out  1  high from start acceptance until DONE.
- done  out  1  sticky; frame fully delivered.
- overflow  out  1  sticky; at least one byte was dropped because the FIFO was full.

Behaviour:
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0; FIFO empty; byte counter=0; state=IDLE; all synchronizer flops=0.
- Synchronizers:
  - cam_pclk, cam_vsync and cam_href each pass through stages s1, s2, s3.
  - cam_data passes through two stages aligned with s1/s2 of cam_pclk.
  - pclk_rise = s2 & ~s3; vs_fall = ~s2 & s3; vs_rise = s2 & ~s3 (on the vsync chain).
- Latency: cam_pclk first sampled high at edge N → push at edge N+2 → wr_valid high after edge N+2 (FIFO was empty). The pushed byte is the cam_data value sampled at edge N.
- States:
  - IDLE: on start, clear overflow, done, the byte counter and wr_addr; set busy=1; go to WAIT_VSYNC.
  - WAIT_VSYNC: on vs_fall, go to CAPTURE. No pushes occur in this state.
  - CAPTURE:
    - Push condition: pclk_rise & href_s2.
    - A push while the FIFO is full drops the byte, sets overflow=1 and does not increment the counter.
    - An accepted push increments the counter.
    - When the counter reaches MAX_BYTES, or on vs_rise (whichever comes first), go to DRAIN.
    - If both occur in the same cycle, the push in that cycle is still taken when the counter is below MAX_BYTES.
  - DRAIN: no pushes; when the FIFO is empty, go to DONE.
  - DONE: done=1, busy=0; go to IDLE in the same cycle. done is held until the next accepted start or reset.
- Handshake:
  - A transfer occurs at a posedge where wr_valid & wr_ready.
  - wr_addr increments by 1 per transfer, wrapping modulo 2^ADDR_W.
  - wr_data and wr_addr are held stable while wr_valid=1 and wr_ready=0.
  - wr_valid depends only on FIFO occupancy; it never depends on wr_ready.
- Simultaneous push and pop:
  - When the FIFO is full, pop and push on the same edge both succeed (no overflow).
  - When the FIFO is empty, the pop is impossible (wr_valid=0), so only the push takes effect.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide with natural wrap; full/empty are derived from the MSB difference.
- A start pulse while busy=1 has no effect.
- Reset asserted mid-capture: all outputs return to reset values immediately (asynchronously); FIFO contents are discarded.

Test Plan:
- Reset, then start; vsync 1→0; one line of href high with 6 pclk pulses, data 0x10..0x15, wr_ready=1 → transfers (addr 0..5, data 0x10..0x15) in order; on vsync 0→1 → done=1, busy=0, overflow=0.
- MAX_BYTES=200, frame of 300 href bytes, wr_ready=1 → exactly 200 transfers, addresses 0..199; done asserts after the FIFO drains; bytes 200+ ignored.
- wr_ready=0 throughout a 6-byte line, FIFO_DEPTH=4 → wr_valid=1 with addr 0 / first byte held stable; overflow=1; after wr_ready=1, exactly 4 transfers (first 4 bytes).
- Bytes arriving before the vsync falling edge (start raised mid-frame) → no pushes until vs_fall; the first transfer carries the first byte of the next frame at addr 0.
- Second start pulse during CAPTURE → ignored (addr sequence continuous); reset asserted mid-capture → wr_valid=0, busy=0, addr=0 without waiting for a clock edge.
- Same-edge push and pop with the FIFO full and wr_ready=1 → no overflow; byte order preserved.

Source files
------------

// File: rtl/cam_frame_capture.sv
// Camera bus capture: resynchronises the parallel camera bus, grabs one frame
// from the next frame boundary and streams it byte by byte with flash addresses.
module cam_frame_capture #(
  parameter int MAX_BYTES  = 200,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    CAPTURE,
    DRAIN
  } state_t;

  state_t        state;
  logic [2:0]    pclk_sr;
  logic [2:0]    vs_sr;
  logic [1:0]    href_sr;
  logic [7:0]    d1;
  logic [7:0]    d2;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic [CW-1:0] count;

  logic pclk_rise;
  logic vs_fall;
  logic vs_rise;
  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push_ok;

  // Bit 0 is the first stage; rising/falling edges are seen between s2 and s3.
  assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);

  assign wr_valid = ~empty;
  assign wr_data  = mem[rptr[PW-1:0]];
  assign pop      = wr_valid & wr_ready;

  // A full FIFO still accepts a byte when its head leaves on the same edge.
  assign push_req = (state == CAPTURE) & pclk_rise & href_sr[1];
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pclk_sr  <= '0;
      vs_sr    <= '0;
      href_sr  <= '0;
      d1       <= '0;
      d2       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wr_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      pclk_sr <= {pclk_sr[1:0], cam_pclk};
      vs_sr   <= {vs_sr[1:0], cam_vsync};
      href_sr <= {href_sr[0], cam_href};
      d1      <= cam_data;
      d2      <= d1;

      if (push_ok) begin
        mem[wptr[PW-1:0]] <= d2;
        wptr <= wptr + (PW+1)'(1);
      end
      if (pop) begin
        rptr    <= rptr + (PW+1)'(1);
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            wr_addr  <= '0;
            busy     <= 1'b1;
            state    <= WAIT_VSYNC;
          end
        end
        WAIT_VSYNC: begin
          if (vs_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (push_req && !push_ok) overflow <= 1'b1;
          if (push_ok) count <= count + CW'(1);
          if ((push_ok && count == CW'(MAX_BYTES - 1)) || vs_rise)
            state <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: directed frames with random pixel data,
// expected transfers derived from which bytes each frame should deliver.
module tb_cam_frame_capture;

  localparam int MAXB  = 200;
  localparam int DEPTH = 4;
  localparam int AW    = 22;

  logic          clock;
  logic          reset;
  logic          start;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          wr_ready;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          overflow;

  cam_frame_capture #(
    .MAX_BYTES (MAXB),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cam_pclk (cam_pclk),
    .cam_vsync(cam_vsync),
    .cam_href (cam_href),
    .cam_data (cam_data),
    .wr_ready (wr_ready),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [AW-1:0] got_addr[$];
  logic [7:0]    got_data[$];

  // Outputs are stable between edges; a handshake seen here completes next edge.
  always @(negedge clock) begin
    if (!reset && wr_valid && wr_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  end

  int         errors = 0;
  int         checks = 0;
  bit         rnd_ready = 0;
  logic [7:0] frame[$];
  logic [7:0] exp_q[$];
  int         base;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One camera pixel clock of 8 system clocks; with sync_pop the ready is
  // raised only for the edge on which the byte is pushed.
  task automatic pulse(input logic hr, input logic [7:0] d,
                       input bit sync_pop = 0);
    cam_pclk = 1'b0;
    cam_href = hr;
    cam_data = d;
    ticks(4);
    cam_pclk = 1'b1;
    ticks(2);
    if (sync_pop) wr_ready = 1'b1;
    tick();
    if (sync_pop) wr_ready = 1'b0;
    tick();
    cam_pclk = 1'b0;
  endtask

  task automatic send(input int from, input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, frame[from + i]);
    cam_href = 1'b0;
    ticks(4);
  endtask

  task automatic set_vsync(input logic v);
    cam_vsync = v;
    ticks(6);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic rand_frame(input int n);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
  endtask

  task automatic expect_transfers(input string tag);
    int n = got_addr.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(got_addr[base + i]), 32'(i));
      chk({tag, "_data"}, 32'(got_data[base + i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    wr_ready  = 1'b1;
    ticks(3);

    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    ticks(6);

    // Basic six-byte line.
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(8'(8'h10 + i));
    exp_q = frame;
    base  = got_addr.size();
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    set_vsync(1'b0);
    send(0, 6);
    set_vsync(1'b1);
    wait_done("t1_done", 200);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    expect_transfers("t1");

    // Frame longer than the byte budget.
    rand_frame(300);
    exp_q.delete();
    for (int i = 0; i < MAXB; i++) exp_q.push_back(frame[i]);
    base = got_addr.size();
    do_start();
    set_vsync(1'b0);
    send(0, 100);
    send(100, 100);
    send(200, 100);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_valid", 32'(wr_valid), 32'd0);
    set_vsync(1'b1);
    chk("t2_busy", 32'(busy), 32'd0);
    expect_transfers("t2");

    // Back-pressure: only the first DEPTH bytes survive.
    rand_frame(6);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(frame[i]);
    base     = got_addr.size();
    wr_ready = 1'b0;
    do_start();
    set_vsync(1'b0);
    pulse(1'b1, frame[0]);
    chk("t3_valid", 32'(wr_valid), 32'd1);
    chk("t3_addr0", 32'(wr_addr), 32'd0);
    chk("t3_data0", 32'(wr_data), 32'(frame[0]));
    send(1, 5);
    chk("t3_hold_addr", 32'(wr_addr), 32'd0);
    chk("t3_hold_data", 32'(wr_data), 32'(frame[0]));
    chk("t3_ovf", 32'(overflow), 32'd1);
    set_vsync(1'b1);
    wr_ready = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);
    expect_transfers("t3");

    // Start raised mid-frame: that frame's bytes are ignored.
    set_vsync(1'b0);
    do_start();
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    rand_frame(8);
    send(0, 3);
    chk("t4_nopush", 32'(wr_valid), 32'd0);
    exp_q.delete();
    for (int i = 3; i < 8; i++) exp_q.push_back(frame[i]);
    base = got_addr.size();
    set_vsync(1'b1);
    set_vsync(1'b0);
    send(3, 5);
    set_vsync(1'b1);
    wait_done("t4_done", 200);
    expect_transfers("t4");

    // Second start during capture, random ready.
    rand_frame(10);
    exp_q = frame;
    base  = got_addr.size();
    rnd_ready = 1;
    do_start();
    set_vsync(1'b0);
    send(0, 4);
    do_start();
    send(4, 6);
    set_vsync(1'b1);
    wait_done("t5_done", 300);
    rnd_ready = 0;
    wr_ready  = 1'b1;
    chk("t5_ovf", 32'(overflow), 32'd0);
    expect_transfers("t5");

    // Asynchronous reset in the middle of a capture.
    rand_frame(3);
    wr_ready = 1'b0;
    do_start();
    set_vsync(1'b0);
    send(0, 3);
    chk("t6_valid_pre", 32'(wr_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(wr_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(wr_addr), 32'd0);
    tick();
    reset = 1'b0;
    set_vsync(1'b1);

    // Push and pop on the same edge while full.
    rand_frame(5);
    exp_q = frame;
    base  = got_addr.size();
    do_start();
    set_vsync(1'b0);
    send(0, 4);
    chk("t7_full_ovf", 32'(overflow), 32'd0);
    pulse(1'b1, frame[4], 1'b1);
    cam_href = 1'b0;
    ticks(4);
    chk("t7_ovf", 32'(overflow), 32'd0);
    wr_ready = 1'b1;
    set_vsync(1'b1);
    wait_done("t7_done", 100);
    expect_transfers("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
